// File: rtl/fmsynth_pkg.sv
// Shared fmsynth definitions: register-port widths and the sequencer queue entry layout.
package fmsynth_pkg;

  localparam int unsigned DELAY_W = 16;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ENTRY_W = DELAY_W + ADDR_W + DATA_W;

  typedef struct packed {
    logic [DELAY_W-1:0] delay;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
  } seq_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, level/full/empty flags and a synchronous flush.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_next;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO is dropped even when a pop frees a slot in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    level_next = level;
    case ({push_ok, pop_ok})
      2'b10:   level_next = level + LVL_W'(1);
      2'b01:   level_next = level - LVL_W'(1);
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level_next;
      full  <= (level_next == LVL_W'(DEPTH));
      empty <= (level_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
    if (pop_ok)  pop_data    <= mem[rd_ptr];
  end

endmodule

// File: rtl/fmsynth_sequencer.sv
// Timed register-write scheduler: queued {delay, addr, data} entries are issued to the fmsynth
// port after <delay> sample ticks, with direct CPU writes taking priority on the same port.
module fmsynth_sequencer
  import fmsynth_pkg::*;
#(
  parameter int unsigned FIFO_LOG2 = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 enable,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [DATA_W-1:0]    cpu_wrdata,
  input  logic                 cpu_wren,
  input  logic [ENTRY_W-1:0]   q_wrdata,
  input  logic                 q_wren,
  input  logic                 q_clear,
  output logic                 q_full,
  output logic [FIFO_LOG2:0]   q_level,
  output logic                 q_overflow,
  output logic                 busy,
  output logic                 irq_empty,
  output logic [ADDR_W-1:0]    fm_addr,
  output logic [DATA_W-1:0]    fm_wrdata,
  output logic                 fm_wren
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_ISSUE} state_t;

  state_t             state;
  logic [DELAY_W-1:0] cnt;
  logic [ENTRY_W-1:0] pop_data;
  seq_entry_t         cur;
  logic               fifo_empty;
  logic               more_c;
  logic               pop_c;

  assign cur    = pop_data;
  assign more_c = enable && !fifo_empty;
  // Pop on the way into LOAD; a stalled ISSUE must keep the current entry in the read register.
  assign pop_c  = !q_clear && more_c &&
                  ((state == S_IDLE) || ((state == S_ISSUE) && !cpu_wren));

  sync_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (FIFO_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (q_clear),
    .push      (q_wren),
    .push_data (q_wrdata),
    .pop       (pop_c),
    .pop_data  (pop_data),
    .level     (q_level),
    .full      (q_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      irq_empty  <= 1'b0;
      q_overflow <= 1'b0;
      fm_addr    <= '0;
      fm_wrdata  <= '0;
      fm_wren    <= 1'b0;
    end else begin
      fm_wren   <= 1'b0;
      irq_empty <= 1'b0;

      if (q_clear)               q_overflow <= 1'b0;
      else if (q_wren && q_full) q_overflow <= 1'b1;

      // CPU writes are forwarded unconditionally, including during a flush.
      if (cpu_wren) begin
        fm_addr   <= cpu_addr;
        fm_wrdata <= cpu_wrdata;
        fm_wren   <= 1'b1;
      end

      if (q_clear) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (more_c) begin
              state <= S_LOAD;
              busy  <= 1'b1;
            end
          end
          S_LOAD: begin
            cnt   <= cur.delay;
            state <= (cur.delay == '0) ? S_ISSUE : S_WAIT;
          end
          S_WAIT: begin
            if (cnt == '0)                  state <= S_ISSUE;
            else if (sample_tick && enable) cnt   <= cnt - DELAY_W'(1);
          end
          S_ISSUE: begin
            if (!cpu_wren) begin
              fm_addr   <= cur.addr;
              fm_wrdata <= cur.data;
              fm_wren   <= 1'b1;
              irq_empty <= fifo_empty && !q_wren;
              if (more_c) begin
                state <= S_LOAD;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
